// File: rtl/div_pkg.sv
// Shared types and constants for the iterative radix-2 restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam logic [4:0]  DIV_LAST_STEP = 5'd31;
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it did not borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;
    logic           borrow;

    always_comb begin
        partial = {rem, quo[WIDTH-1]};
        diff    = partial - {1'b0, divisor};
        borrow  = (partial < {1'b0, divisor});
        if (borrow) begin
            rem_next = partial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// DIV/DIVU unit for the EX stage: quotient to LO, remainder to HI, level stall.
// Optional build macro DIV_EARLY_OUT_EN finishes |dividend| < |divisor| in one cycle.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             stall_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    div_state_e       state_reg, state_next;
    logic [4:0]       cnt_reg;
    logic [WIDTH-1:0] rem_reg, quo_reg, dsr_reg;
    logic [WIDTH-1:0] rem_next, quo_next;
    logic             sign_q_reg, sign_r_reg, dz_reg;
    logic [WIDTH-1:0] quotient_reg, remainder_reg;
    logic [WIDTH-1:0] abs_dividend, abs_divisor;
    logic [WIDTH-1:0] fix_quot, fix_rem;
    logic             neg_dividend, neg_divisor;
    logic             accept, last_step, early_out;

    assign neg_dividend = signed_i & dividend_i[WIDTH-1];
    assign neg_divisor  = signed_i & divisor_i[WIDTH-1];
    assign abs_dividend = neg_dividend ? -dividend_i : dividend_i;
    assign abs_divisor  = neg_divisor  ? -divisor_i  : divisor_i;

    assign accept    = (state_reg == IDLE) & start_i & ~annul_i;
    assign last_step = (cnt_reg == DIV_LAST_STEP);

`ifdef DIV_EARLY_OUT_EN
    assign early_out = (divisor_i != '0) && (abs_dividend < abs_divisor);
`else
    assign early_out = 1'b0;
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem_reg),
        .quo     (quo_reg),
        .divisor (dsr_reg),
        .rem_next(rem_next),
        .quo_next(quo_next)
    );

    // With a zero divisor the steps leave |dividend| in rem, so the remainder
    // negate below restores the original dividend bit-for-bit.
    assign fix_quot = dz_reg     ? WIDTH'(DIV_ZERO_QUOT)
                    : sign_q_reg ? -quo_next : quo_next;
    assign fix_rem  = sign_r_reg ? -rem_next : rem_next;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = early_out ? DONE : BUSY;
            BUSY:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (annul_i) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        ready_o = (state_reg == DONE);
    end

    assign stall_o     = start_i & ~ready_o & ~annul_i;
    assign quotient_o  = quotient_reg;
    assign remainder_o = remainder_reg;

    // Results only move on a completing edge, so an annulled operation
    // leaves the previous LO/HI values visible.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_reg       <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            dsr_reg       <= '0;
            sign_q_reg    <= 1'b0;
            sign_r_reg    <= 1'b0;
            dz_reg        <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else if (accept) begin
            cnt_reg    <= '0;
            rem_reg    <= '0;
            quo_reg    <= abs_dividend;
            dsr_reg    <= abs_divisor;
            sign_q_reg <= neg_dividend ^ neg_divisor;
            sign_r_reg <= neg_dividend;
            dz_reg     <= (divisor_i == '0);
            if (early_out) begin
                quotient_reg  <= '0;
                remainder_reg <= dividend_i;
            end
        end else if (state_reg == BUSY && !annul_i) begin
            cnt_reg <= cnt_reg + 5'd1;
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            if (last_step) begin
                quotient_reg  <= fix_quot;
                remainder_reg <= fix_rem;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, randomized operands,
// annul, back-to-back and asynchronous reset, checked against an arithmetic model.
module tb_div_unit;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic        signed_i;
    logic        annul_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        stall_o;
    logic        ready_o;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;

    int n_vec = 0;
    int n_err = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    div_unit #(.WIDTH(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .annul_i    (annul_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .stall_o    (stall_o),
        .ready_o    (ready_o),
        .quotient_o (quotient_o),
        .remainder_o(remainder_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference: truncating division on 64-bit integers, remainder takes the dividend's sign.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            return;
        end
        sa = s ? {{32{a[31]}}, a} : {32'd0, a};
        sb = s ? {{32{b[31]}}, b} : {32'd0, b};
        lq = sa / sb;
        lr = sa % sb;
        q  = lq[31:0];
        r  = lr[31:0];
    endfunction

    function automatic int exp_stalls(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint ma, mb;
        ma = {32'd0, a};
        mb = {32'd0, b};
        if (s && a[31]) ma = 64'h1_0000_0000 - ma;
        if (s && b[31]) mb = 64'h1_0000_0000 - mb;
        if (EARLY && b != 32'd0 && ma < mb) return 1;
        return 33;
    endfunction

    // Issues one operation, counts stall cycles, scrambles operands after accept.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] q, output logic [31:0] r,
                          output int stalls, output bit ok);
        ok = 1'b0;
        stalls = 0;
        q = '0;
        r = '0;
        @(negedge clk_i);
        dividend_i = a;
        divisor_i  = b;
        signed_i   = s;
        start_i    = 1'b1;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (ready_o) begin
                q  = quotient_o;
                r  = remainder_o;
                ok = 1'b1;
                break;
            end
            if (stall_o) stalls++;
            @(negedge clk_i);
            if (c == 0) begin
                dividend_i = $urandom;
                divisor_i  = $urandom;
                signed_i   = ~s;
            end
        end
        start_i = 1'b0;
        $display("op a=%h b=%h s=%0d -> q=%h r=%h stalls=%0d", a, b, s, q, r, stalls);
        @(negedge clk_i);
    endtask

    task automatic test_reset;
        @(negedge clk_i);
        #1;
        n_vec++;
        if (ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 0", ready_o);
        end
        n_vec++;
        if (quotient_o !== 32'd0 || remainder_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got q=%h r=%h want 0/0", quotient_o, remainder_o);
        end
        n_vec++;
        if (stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_stall: got %b want 0", stall_o);
        end
    endtask

    task automatic test_directed;
        logic [31:0] ta[7] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'd3, 32'hFFFF_FFF9, 32'd7};
        logic [31:0] tb[7] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd10, 32'd0, 32'hFFFF_FFFE};
        logic        ts[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] tq[7] = '{32'd14, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFD};
        logic [31:0] tr[7] = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'd5, 32'd3, 32'hFFFF_FFF9, 32'd1};
        logic [31:0] q, r;
        int          st;
        bit          ok;
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb[i], ts[i], q, r, st, ok);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL directed_%0d_timeout: no ready_o within 100 cycles", i);
            end else begin
                n_vec++;
                if (q !== tq[i] || r !== tr[i]) begin
                    n_err++;
                    $display("FAIL directed_%0d_result: got q=%h r=%h want q=%h r=%h", i, q, r, tq[i], tr[i]);
                end
                n_vec++;
                if (st !== exp_stalls(ta[i], tb[i], ts[i])) begin
                    n_err++;
                    $display("FAIL directed_%0d_stalls: got %0d want %0d", i, st, exp_stalls(ta[i], tb[i], ts[i]));
                end
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b, q, r, eq, er;
        logic        s;
        int          st;
        bit          ok;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            if (i % 5 == 1) a = $urandom_range(0, 1000);
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 255);
                2:       b = 32'd0 - $urandom_range(1, 300);
                3:       b = (i % 2 == 0) ? 32'd0 : 32'd1;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            s = 1'($urandom_range(0, 1));
            model(a, b, s, eq, er);
            run_op(a, b, s, q, r, st, ok);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL random_%0d_timeout: no ready_o within 100 cycles", i);
            end else begin
                n_vec++;
                if (q !== eq || r !== er) begin
                    n_err++;
                    $display("FAIL random_%0d_result: a=%h b=%h s=%0d got q=%h r=%h want q=%h r=%h",
                             i, a, b, s, q, r, eq, er);
                end
                n_vec++;
                if (st !== exp_stalls(a, b, s)) begin
                    n_err++;
                    $display("FAIL random_%0d_stalls: got %0d want %0d", i, st, exp_stalls(a, b, s));
                end
            end
        end
    endtask

    task automatic test_annul;
        logic [31:0] q, r;
        int          st, pulses;
        bit          ok;
        run_op(32'd50, 32'd7, 1'b0, q, r, st, ok);
        @(negedge clk_i);
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        signed_i   = 1'b0;
        start_i    = 1'b1;
        repeat (11) @(negedge clk_i);
        annul_i = 1'b1;
        #1;
        n_vec++;
        if (stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL annul_stall: got %b want 0", stall_o);
        end
        @(negedge clk_i);
        annul_i = 1'b0;
        start_i = 1'b0;
        #1;
        n_vec++;
        if (ready_o !== 1'b0 || quotient_o !== 32'd7 || remainder_o !== 32'd1) begin
            n_err++;
            $display("FAIL annul_hold: got ready=%b q=%h r=%h want ready=0 q=7 r=1",
                     ready_o, quotient_o, remainder_o);
        end
        // start together with annul in IDLE must not be accepted
        start_i = 1'b1;
        annul_i = 1'b1;
        repeat (3) @(negedge clk_i);
        start_i = 1'b0;
        annul_i = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (ready_o) pulses++;
            @(negedge clk_i);
        end
        n_vec++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL annul_no_ready: got %0d ready pulses want 0", pulses);
        end
        run_op(32'd9, 32'd3, 1'b0, q, r, st, ok);
        n_vec++;
        if (!ok || q !== 32'd3 || r !== 32'd0 || st !== 33) begin
            n_err++;
            $display("FAIL annul_fresh_op: got ok=%0d q=%h r=%h stalls=%0d want q=3 r=0 stalls=33",
                     ok, q, r, st);
        end
    endtask

    task automatic test_back_to_back;
        int          t[2];
        logic [31:0] qq[2], rr[2];
        int          npulse;
        @(negedge clk_i);
        dividend_i = 32'd10;
        divisor_i  = 32'd3;
        signed_i   = 1'b0;
        start_i    = 1'b1;
        npulse     = 0;
        t[0] = 0; t[1] = 0;
        qq[0] = '0; qq[1] = '0; rr[0] = '0; rr[1] = '0;
        for (int c = 0; c < 120 && npulse < 2; c++) begin
            #1;
            if (ready_o) begin
                t[npulse]  = c;
                qq[npulse] = quotient_o;
                rr[npulse] = remainder_o;
                npulse++;
                if (npulse == 1) begin
                    dividend_i = 32'd20;
                    divisor_i  = 32'd6;
                end else begin
                    start_i = 1'b0;
                end
            end
            @(negedge clk_i);
        end
        start_i = 1'b0;
        $display("b2b pulses=%0d t0=%0d t1=%0d r0=%h/%h r1=%h/%h", npulse, t[0], t[1], qq[0], rr[0], qq[1], rr[1]);
        n_vec++;
        if (npulse !== 2) begin
            n_err++;
            $display("FAIL b2b_pulses: got %0d want 2", npulse);
        end else begin
            n_vec++;
            if (t[1] - t[0] !== 34) begin
                n_err++;
                $display("FAIL b2b_spacing: got %0d want 34", t[1] - t[0]);
            end
            n_vec++;
            if (qq[0] !== 32'd3 || rr[0] !== 32'd1 || qq[1] !== 32'd3 || rr[1] !== 32'd2) begin
                n_err++;
                $display("FAIL b2b_results: got %h/%h %h/%h want 3/1 3/2", qq[0], rr[0], qq[1], rr[1]);
            end
        end
        @(negedge clk_i);
    endtask

    task automatic test_async_reset;
        logic [31:0] q, r;
        int          st;
        bit          ok;
        @(negedge clk_i);
        dividend_i = 32'd77;
        divisor_i  = 32'd5;
        signed_i   = 1'b0;
        start_i    = 1'b1;
        repeat (5) @(negedge clk_i);
        #2;
        start_i = 1'b0;
        rst_i   = 1'b0;
        #1;
        n_vec++;
        if (ready_o !== 1'b0 || quotient_o !== 32'd0 || remainder_o !== 32'd0) begin
            n_err++;
            $display("FAIL async_reset: got ready=%b q=%h r=%h want 0/0/0", ready_o, quotient_o, remainder_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        run_op(32'd9, 32'd3, 1'b0, q, r, st, ok);
        n_vec++;
        if (!ok || q !== 32'd3 || r !== 32'd0 || st !== 33) begin
            n_err++;
            $display("FAIL post_reset_op: got ok=%0d q=%h r=%h stalls=%0d want q=3 r=0 stalls=33",
                     ok, q, r, st);
        end
    endtask

    initial begin
        rst_i      = 1'b0;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        annul_i    = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        repeat (2) @(negedge clk_i);
        test_reset();
        rst_i = 1'b1;
        test_directed();
        test_random();
        test_annul();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
